brightness_frame_sequencer: RTL
===============================

// Module: brightness_frame_sequencer
// PURPOSE
// - Sequences one frame through brightness_processor: latches mode/proc_val/word count on cfg_start,
//   pulls words from an upstream valid/ready stream, drives bp_vld/bp_last_data, absorbs the fixed
//   1-cycle processor latency in an output FIFO, and presents results on a downstream valid/ready stream.
// - Sits between the DMA/line-buffer source and the writeback sink; owns all brightness_processor inputs.
// PARAMETERS
// - DATA_WIDTH  32  word width; must equal the processor's DATA_WIDTH (32 or 64)
// - CNT_W       20  width of the frame word counter (max 2^CNT_W-1 words per frame)
// - FIFO_DEPTH  4   output FIFO entries; power of 2, >=2
// PORTS
// - clk              in   1           clock
// - rst_n            in   1           async active-low reset
// - cfg_start        in   1           1-cycle pulse: begin a frame (ignored when busy=1)
// - cfg_mode         in   2           processor mode, latched on accepted cfg_start
// - cfg_proc_val     in   COLOR_SIZE  threshold/brightness value, latched on accepted cfg_start
// - cfg_num_words    in   CNT_W       words in frame, latched on accepted cfg_start
// - cfg_abort        in   1           1-cycle pulse: abandon current frame
// - busy             out  1           frame in progress (state != IDLE)
// - frame_done       out  1           1-cycle pulse: last word accepted by sink, or abort completed
// - src_vld/src_rdy  in/out 1         upstream handshake; word transfers when both high
// - src_data         in   DATA_WIDTH  upstream word
// - bp_vld           out  1           processor vld
// - bp_last_data     out  1           processor last_data; high with final issued word only
// - bp_mode          out  2           latched mode, constant for whole frame
// - bp_proc_val      out  COLOR_SIZE  latched proc_val, constant for whole frame
// - bp_data_in       out  DATA_WIDTH  word to processor (= src_data, combinational passthrough)
// - bp_data_out      in   DATA_WIDTH  processor result
// - bp_data_out_vld  in   1           processor result valid (exactly 1 cycle after bp_vld)
// - bp_done          in   1           processor done; monitored only, not used for completion
// - snk_vld/snk_rdy  out/in 1         downstream handshake
// - snk_data         out  DATA_WIDTH  FIFO head
// BEHAVIOUR
// - Reset: busy=0, frame_done=0, src_rdy=0, bp_vld=0, bp_last_data=0, bp_mode=0, bp_proc_val=0,
//   snk_vld=0; FIFO empty, counters 0, state IDLE. Reset mid-frame discards all data, no frame_done.
// - FSM: IDLE -> (cfg_start & num_words!=0) RUN; IDLE -> (cfg_start & num_words==0) DONE;
//   RUN -> (issue_cnt==num_words) DRAIN; DRAIN -> (out_cnt==num_words & FIFO empty) DONE;
//   DONE -> IDLE (frame_done=1 this cycle only). cfg_abort in RUN/DRAIN -> FLUSH;
//   FLUSH -> DONE once in-flight word lands; FIFO cleared on FLUSH exit; cfg_abort in IDLE/DONE ignored.
// - Issue (RUN only): src_rdy = (occupancy + inflight < FIFO_DEPTH). Transfer => bp_vld=1 same cycle,
//   issue_cnt++; bp_last_data=1 iff issue_cnt==num_words-1. inflight = registered bp_vld (0 or 1).
// - Credit rule guarantees every bp_data_out_vld finds a free FIFO slot; push with no space is a
//   design error -> assertion, no overflow handling in RTL.
// - FIFO: push on bp_data_out_vld, pop on snk_vld&snk_rdy; simultaneous push+pop keeps occupancy;
//   pop-and-push when full is legal. snk_vld = !empty. Pointers wrap mod FIFO_DEPTH, extra wrap bit
//   for full/empty. out_cnt increments per pop.
// - Latency: src accept -> FIFO entry 1 cycle (processor) + 1 cycle (FIFO write) -> snk_vld earliest
//   2 cycles after src transfer. Full throughput (1 word/clk) when snk_rdy held high and FIFO_DEPTH>=2.
// - bp_mode/bp_proc_val update only on accepted cfg_start; stable from IDLE exit to next start.
// - Counters are CNT_W bits unsigned; no wrap within a frame since num_words <= 2^CNT_W-1.
// - bp_done asserted while issue_cnt!=num_words -> assertion failure (protocol check only).
// STRUCTURE
// - Shared package: COLOR_SIZE (8), mode encodings MODE_NONE/THRESH/BRIGHT/RSVD = 0..3,
//   FSM state enum {IDLE,RUN,DRAIN,FLUSH,DONE}.
// - One sub-module: sync_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/count, async rst_n).
// - brightness_processor instantiated by the parent, not inside this block.
// TESTING
// - cfg_num_words=4, mode=2, proc_val=8'h10, src always valid, snk_rdy=1 -> 4 back-to-back bp_vld,
//   bp_last_data only on 4th, frame_done one cycle after 4th snk transfer.
// - cfg_num_words=0 -> busy high 1 cycle, frame_done pulse next cycle, bp_vld never asserted.
// - snk_rdy=0 for 10 cycles mid-frame, FIFO_DEPTH=4 -> at most 4 words issued, src_rdy=0 until pop,
//   no word lost or duplicated (scoreboard vs reference model).
// - cfg_start pulsed while busy with cfg_mode=1 -> ignored; bp_mode stays 2 until frame_done.
// - cfg_abort after 3 of 8 words issued -> FLUSH, FIFO emptied, frame_done pulse, new start accepted.
// - rst_n low mid-DRAIN -> all outputs at reset values immediately, next frame runs clean.

Source files
------------

// File: rtl/brightness_frame_sequencer_pkg.sv
// Shared types and constants for the brightness frame sequencer and its
// surrounding brightness_processor datapath.
package brightness_frame_sequencer_pkg;

  localparam int COLOR_SIZE = 8;

  localparam logic [1:0] MODE_NONE   = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_BRIGHT = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/brightness_frame_sequencer_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count and a synchronous
// clear that takes priority over push/pop.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/brightness_frame_sequencer.sv
// Runs one frame through brightness_processor: issues source words under a
// FIFO credit limit and buffers the 1-cycle-late results for the sink.
module brightness_frame_sequencer
  import brightness_frame_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [1:0]            cfg_mode,
  input  logic [COLOR_SIZE-1:0] cfg_proc_val,
  input  logic [CNT_W-1:0]      cfg_num_words,
  input  logic                  cfg_abort,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  src_vld,
  output logic                  src_rdy,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  bp_vld,
  output logic                  bp_last_data,
  output logic [1:0]            bp_mode,
  output logic [COLOR_SIZE-1:0] bp_proc_val,
  output logic [DATA_WIDTH-1:0] bp_data_in,
  input  logic [DATA_WIDTH-1:0] bp_data_out,
  input  logic                  bp_data_out_vld,
  input  logic                  bp_done,
  output logic                  snk_vld,
  input  logic                  snk_rdy,
  output logic [DATA_WIDTH-1:0] snk_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);

  state_t           state;
  logic [CNT_W-1:0] num_words;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             inflight;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_clr;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;
  logic             snk_pop;
  logic             last_issue;
  logic             last_pop;

  // A word popped this cycle frees its slot in time for a word issued now,
  // which keeps one word per clock even with a 2-entry FIFO.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, snk_pop};

  assign last_issue   = (issue_cnt == num_words - 1'b1);
  assign last_pop     = (out_cnt == num_words - 1'b1);
  assign src_rdy      = (state == RUN) && !cfg_abort && (issue_cnt != num_words)
                        && (credit_used < DEPTH_LIMIT);
  assign bp_vld       = src_vld && src_rdy;
  assign bp_last_data = bp_vld && last_issue;
  assign bp_data_in   = src_data;
  assign snk_vld      = !fifo_empty;
  assign snk_pop      = snk_vld && snk_rdy;
  assign fifo_clr     = (state == FLUSH) && !inflight;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      num_words   <= '0;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      inflight    <= 1'b0;
      bp_mode     <= MODE_NONE;
      bp_proc_val <= '0;
    end else begin
      inflight <= bp_vld;
      if (bp_vld)  issue_cnt <= issue_cnt + 1'b1;
      if (snk_pop) out_cnt   <= out_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            bp_mode     <= cfg_mode;
            bp_proc_val <= cfg_proc_val;
            num_words   <= cfg_num_words;
            issue_cnt   <= '0;
            out_cnt     <= '0;
            state       <= (cfg_num_words == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (cfg_abort)         state <= FLUSH;
          else if (bp_last_data) state <= DRAIN;
        end
        DRAIN: begin
          // The final pop empties the FIFO, since every issued word has been counted out.
          if (cfg_abort)                state <= FLUSH;
          else if (snk_pop && last_pop) state <= DONE;
        end
        FLUSH: begin
          if (!inflight) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fifo_clr),
    .push      (bp_data_out_vld),
    .push_data (bp_data_out),
    .pop       (snk_pop),
    .pop_data  (snk_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    bp_data_out_vld |-> (!fifo_full || snk_pop));

  a_done_after_last: assert property (@(posedge clk) disable iff (!rst_n)
    bp_done |-> (issue_cnt == num_words));

endmodule
